scaler_video_out: RTL

- Downstream stage of streamScaler. Consumes the scaled pixel stream (dOut/dOutValid/nextDout) and turns it into a raster display stream with HSYNC/VSYNC/DE.
- Holds a small first-word-fall-through FIFO between the scaler and the timing generator, so scaler output bursts are decoupled from the fixed display pixel rate.
- Issues the scaler's per-frame start pulse, and flags underflow and overflow.

---
 rtl/scaler_pkg.sv | 18 +
 rtl/scaler_video_out_fifo.sv | 46 ++++
 rtl/scaler_video_out.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared constants and state encoding for the scaler display output stage.
// Defaults describe a 1280x960 raster fed by 8-bit RGB pixels.
package scaler_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CHANNELS   = 3;
  localparam int PIX_W          = DEF_DATA_WIDTH * DEF_CHANNELS;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 96;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BP     = 312;
  localparam int DEF_V_ACTIVE = 960;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 36;

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN} state_t;
endpackage

// File: rtl/scaler_video_out_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module stream_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/scaler_video_out.sv
// Display timing generator fed from the scaler through a small FWFT FIFO.
// Emits registered raster video, the scaler start pulse and sticky error flags.
module scaler_video_out
  import scaler_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int FIFO_DEPTH = 16,
  parameter int SKID       = 4,
  parameter int PREFILL    = 8,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter logic [DATA_WIDTH*CHANNELS-1:0] UNDERFLOW_COLOR = (DATA_WIDTH*CHANNELS)'(24'hFF00FF)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [DATA_WIDTH*CHANNELS-1:0] dIn,
  input  logic                           dInValid,
  output logic                           nextDin,
  output logic                           scalerStart,
  output logic [DATA_WIDTH*CHANNELS-1:0] vidData,
  output logic                           vidDe,
  output logic                           vidHsync,
  output logic                           vidVsync,
  output logic                           underflow,
  output logic                           overflow,
  input  logic                           clearErr
);
  localparam int PW      = DATA_WIDTH * CHANNELS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] NEXT_LIM    = CW'(FIFO_DEPTH - SKID);
  localparam logic [CW-1:0] PREFILL_LIM = CW'(PREFILL);

  state_t          state, state_d;
  logic [HW-1:0]   h_cnt, h_d;
  logic [VW-1:0]   v_cnt, v_d;
  logic            run, de, hs_on, vs_on, line_end, frame_end, flush, pop;
  logic            uf_set, ov_set;
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  logic            empty, full;

  stream_fifo_fwft #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (dInValid),
    .din   (dIn),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign run       = (state == S_RUN);
  assign de        = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on     = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on     = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = run && line_end && (v_cnt == V_LAST);
  // Entering vertical blank: drop leftovers so the next frame starts aligned.
  assign flush     = run && (h_cnt == '0) && (v_cnt == V_ACT);
  assign pop       = de && !empty;
  assign uf_set    = de && empty;
  assign ov_set    = dInValid && !flush && full && !pop;

  always_comb begin
    state_d = state;
    h_d     = h_cnt;
    v_d     = v_cnt;
    case (state)
      S_IDLE:    if (enable) state_d = S_PREFILL;
      S_PREFILL: if (count >= PREFILL_LIM) begin
        state_d = S_RUN;
        h_d     = '0;
        v_d     = '0;
      end
      S_RUN: begin
        h_d = line_end ? '0 : h_cnt + 1'b1;
        if (line_end) v_d = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        if (frame_end && !enable) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_d;
      h_cnt <= h_d;
      v_cnt <= v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vidData     <= '0;
      vidDe       <= 1'b0;
      vidHsync    <= !HS_POL;
      vidVsync    <= !VS_POL;
      nextDin     <= 1'b0;
      scalerStart <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      vidData     <= de ? (empty ? UNDERFLOW_COLOR : head) : '0;
      vidDe       <= de;
      vidHsync    <= hs_on ? HS_POL : !HS_POL;
      vidVsync    <= vs_on ? VS_POL : !VS_POL;
      nextDin     <= (state != S_IDLE) && (count < NEXT_LIM);
      scalerStart <= ((state == S_IDLE) && enable) || flush;
      underflow   <= uf_set || (underflow && !clearErr);
      overflow    <= ov_set || (overflow && !clearErr);
    end
  end
endmodule
